// File: rtl/maxpool_pkg.sv
// Definitions shared by the 2x2 maxpool feeder and the maxpool consumer:
// default pixel width, window slot numbering and the packed window layout.
package maxpool_pkg;

  localparam int PIX_W_DEF = 4;

  localparam int SLOT_TL = 0;
  localparam int SLOT_TR = 1;
  localparam int SLOT_BL = 2;
  localparam int SLOT_BR = 3;
  localparam int SLOTS   = 4;

  // Concatenation order {pixel4, pixel3, pixel2, pixel1}; pixel1 sits in the LSBs.
  typedef struct packed {
    logic [PIX_W_DEF-1:0] pixel4;
    logic [PIX_W_DEF-1:0] pixel3;
    logic [PIX_W_DEF-1:0] pixel2;
    logic [PIX_W_DEF-1:0] pixel1;
  } window_t;

endpackage

// File: rtl/maxpool_line_buf.sv
// One-line pixel store: a single write port and two asynchronous read ports.
// The feeder reads both pixels of the top row of a window in the same cycle.
module maxpool_line_buf #(
  parameter int PIX_W = 4,
  parameter int IMG_W = 8,
  parameter int AW    = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [AW-1:0]    raddr0,
  input  logic [AW-1:0]    raddr1,
  output logic [PIX_W-1:0] rdata0,
  output logic [PIX_W-1:0] rdata1
);

  // Contents are never reset: every entry is written on an even row before it is read.
  logic [PIX_W-1:0] mem [IMG_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/maxpool_window_feeder.sv
// Turns a raster-scan pixel stream into non-overlapping 2x2 windows (stride 2)
// with a valid/ready output that can replace a pending window without a bubble.
module maxpool_window_feeder
  import maxpool_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             in_ready,
  output logic             win_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] pixel1,
  output logic [PIX_W-1:0] pixel2,
  output logic [PIX_W-1:0] pixel3,
  output logic [PIX_W-1:0] pixel4,
  output logic             win_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2) begin : g_param_check
    $error("maxpool_window_feeder: IMG_W and IMG_H must be even and >= 2");
  end

  logic [CW-1:0]    col_reg;
  logic [RW-1:0]    row_reg;
  logic [PIX_W-1:0] bl_reg;
  logic [PIX_W-1:0] win_reg [SLOTS];
  logic             win_valid_reg;
  logic             win_last_reg;

  logic             accept;
  logic             col_last;
  logic             row_last;
  logic             complete;
  logic [PIX_W-1:0] top_left;
  logic [PIX_W-1:0] top_right;

  assign in_ready = ~win_valid_reg | out_ready;
  assign accept   = in_valid & in_ready;
  assign col_last = (col_reg == CW'(IMG_W - 1));
  assign row_last = (row_reg == RW'(IMG_H - 1));
  assign complete = accept & row_reg[0] & col_reg[0];

  // Read addresses are only meaningful on odd columns, where col-1 never underflows.
  maxpool_line_buf #(
    .PIX_W (PIX_W),
    .IMG_W (IMG_W),
    .AW    (CW)
  ) u_line_buf (
    .clk    (clk),
    .we     (accept & ~row_reg[0]),
    .waddr  (col_reg),
    .wdata  (in_pixel),
    .raddr0 (col_reg - CW'(1)),
    .raddr1 (col_reg),
    .rdata0 (top_left),
    .rdata1 (top_right)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg       <= '0;
      row_reg       <= '0;
      bl_reg        <= '0;
      win_valid_reg <= 1'b0;
      win_last_reg  <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        win_reg[i] <= '0;
      end
    end else begin
      if (accept) begin
        if (col_last) begin
          col_reg <= '0;
          row_reg <= row_last ? '0 : row_reg + RW'(1);
        end else begin
          col_reg <= col_reg + CW'(1);
        end
        if (row_reg[0] && !col_reg[0]) begin
          bl_reg <= in_pixel;
        end
      end
      // A completing window overrides the take, so a concurrent take never leaves a bubble.
      if (complete) begin
        win_reg[SLOT_TL] <= top_left;
        win_reg[SLOT_TR] <= top_right;
        win_reg[SLOT_BL] <= bl_reg;
        win_reg[SLOT_BR] <= in_pixel;
        win_valid_reg    <= 1'b1;
        win_last_reg     <= row_last & col_last;
      end else if (out_ready) begin
        win_valid_reg <= 1'b0;
        win_last_reg  <= 1'b0;
      end
    end
  end

  assign win_valid = win_valid_reg;
  assign win_last  = win_last_reg;
  assign pixel1    = win_reg[SLOT_TL];
  assign pixel2    = win_reg[SLOT_TR];
  assign pixel3    = win_reg[SLOT_BL];
  assign pixel4    = win_reg[SLOT_BR];

endmodule
